// File: rtl/alu_pkg.sv
// Shared datapath control word for the 4-bit ALU stage and its command arbiter.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

    typedef struct packed {
        alu_op_t op;
        logic    cin;
        logic    sat;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_arb_4b.sv
// Two-requester arbiter in front of a single 4-bit ALU stage.
// Commands are muxed combinationally to the ALU. The arbiter tracks which
// requester owns the single outstanding result and steers it back.
// No cycles are added in either direction.
module alu_arb_4b
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             rq0_valid,
    output logic             rq0_ready,
    input  logic [3:0]       rq0_x0,
    input  logic [3:0]       rq0_x1,
    input  logic [3:0]       rq0_y0,
    input  logic [3:0]       rq0_y1,
    input  alu_ctrl_t        rq0_ctrl,

    input  logic             rq1_valid,
    output logic             rq1_ready,
    input  logic [3:0]       rq1_x0,
    input  logic [3:0]       rq1_x1,
    input  logic [3:0]       rq1_y0,
    input  logic [3:0]       rq1_y1,
    input  alu_ctrl_t        rq1_ctrl,

    output logic             rs0_valid,
    input  logic             rs0_ready,
    output logic [9:0]       rs0_res,
    output logic             rs0_carry,

    output logic             rs1_valid,
    input  logic             rs1_ready,
    output logic [9:0]       rs1_res,
    output logic             rs1_carry,

    output logic             alu_cmd_valid,
    input  logic             alu_cmd_ready,
    output logic [3:0]       alu_x0,
    output logic [3:0]       alu_x1,
    output logic [3:0]       alu_y0,
    output logic [3:0]       alu_y1,
    output alu_ctrl_t        alu_ctrl,

    input  logic             alu_res_valid,
    output logic             alu_res_ready,
    input  logic [9:0]       alu_res_q,
    input  logic             alu_carry_q,

    output logic             owner,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   owner_q, owner_nxt;
    logic   lock_q;
    logic   lock_id_q;
    logic   last_gnt_q;
    logic   grant;
    logic   cmd_fire;
    logic   res_fire;

    // Grant: a stalled command keeps its grant; otherwise round-robin on ties
    always_comb begin
        grant = last_gnt_q;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (rq0_valid && !rq1_valid) begin
            grant = 1'b0;
        end else if (rq1_valid && !rq0_valid) begin
            grant = 1'b1;
        end else if (rq0_valid && rq1_valid) begin
            grant = ~last_gnt_q;
        end
    end

    // Zero-latency command mux; everything is held at zero while in reset
    always_comb begin
        alu_cmd_valid = 1'b0;
        alu_x0        = '0;
        alu_x1        = '0;
        alu_y0        = '0;
        alu_y1        = '0;
        alu_ctrl      = '0;
        rq0_ready     = 1'b0;
        rq1_ready     = 1'b0;
        if (!rst) begin
            rq0_ready = !grant && alu_cmd_ready;
            rq1_ready = grant && alu_cmd_ready;
            if (grant) begin
                alu_cmd_valid = rq1_valid;
                alu_x0        = rq1_x0;
                alu_x1        = rq1_x1;
                alu_y0        = rq1_y0;
                alu_y1        = rq1_y1;
                alu_ctrl      = rq1_ctrl;
            end else begin
                alu_cmd_valid = rq0_valid;
                alu_x0        = rq0_x0;
                alu_x1        = rq0_x1;
                alu_y0        = rq0_y0;
                alu_y1        = rq0_y1;
                alu_ctrl      = rq0_ctrl;
            end
        end
    end

    assign cmd_fire = alu_cmd_valid && alu_cmd_ready;
    assign busy     = (state == S_PEND);
    assign owner    = owner_q;

    // Result return path: only the owner sees the ALU result, and only while busy
    always_comb begin
        rs0_valid     = 1'b0;
        rs1_valid     = 1'b0;
        rs0_res       = '0;
        rs1_res       = '0;
        rs0_carry     = 1'b0;
        rs1_carry     = 1'b0;
        alu_res_ready = 1'b0;
        if (busy && !rst) begin
            alu_res_ready = owner_q ? rs1_ready : rs0_ready;
            if (owner_q) begin
                rs1_valid = alu_res_valid;
                rs1_res   = alu_res_q;
                rs1_carry = alu_carry_q;
            end else begin
                rs0_valid = alu_res_valid;
                rs0_res   = alu_res_q;
                rs0_carry = alu_carry_q;
            end
        end
    end

    assign res_fire = alu_res_valid && alu_res_ready;

    // Next state and next owner of the outstanding result
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = S_PEND;
                    owner_nxt = grant;
                end
            end
            S_PEND: begin
                // A new command while the old result has not left cannot be
                // accepted by a one-slot ALU stage, so only the paired case
                // hands ownership over.
                if (res_fire && cmd_fire) begin
                    owner_nxt = grant;
                end else if (res_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outstanding-result state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            owner_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
        end
    end

    // Grant lock: hold the grant of a command the ALU has not yet taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else if (cmd_fire) begin
            lock_q    <= 1'b0;
        end else if (alu_cmd_valid && !alu_cmd_ready) begin
            lock_q    <= 1'b1;
            lock_id_q <= grant;
        end
    end

    // Round-robin pointer; reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (cmd_fire) begin
            last_gnt_q <= grant;
        end
    end

    // Per-requester accepted-command counters, free-running wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (cmd_fire) begin
            if (grant) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end else begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
        end
    end

    // Sticky error: a result arrived with nothing outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (alu_res_valid && !busy) begin
            err <= 1'b1;
        end
    end

endmodule
